clk_sel_glitchfree: RTL and testbench

Glitch-free 4:1 clock selector that sits directly downstream of the clock divider. It takes the divide-by-2/3/4/5 clocks and drives one of them onto a single output clock. Requests are made in the `clk` domain through a req/ack handshake. A switch never produces a runt pulse or a shortened phase on `o_clk`: the old source is gated off on its own falling edge, and the new source is gated on only after every leg reports disabled.

---
 rtl/clk_sel_pkg.sv | 25 ++
 rtl/clk_sel_glitchfree_if.sv | 27 ++
 rtl/clk_sel_leg.sv | 37 +++
 rtl/clk_sel_glitchfree.sv | 131 +++++++++++++
 tb/tb_clk_sel_glitchfree.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_sel_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the glitch-free 4:1 clock selector.
package clk_sel_pkg;

    localparam int N_LEGS = 4;

    typedef enum logic [1:0] {
        SEL_DIV2 = 2'd0,
        SEL_DIV3 = 2'd1,
        SEL_DIV4 = 2'd2,
        SEL_DIV5 = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DROP  = 2'd1,
        RAISE = 2'd2,
        ACK   = 2'd3
    } clk_sel_state_e;

    function automatic logic [N_LEGS-1:0] sel_onehot(input sel_e sel);
        sel_onehot = N_LEGS'(1) << sel;
    endfunction

endpackage

// File: rtl/clk_sel_glitchfree_if.sv
`timescale 1ns/1ps
// Control-domain request/acknowledge bundle of the clock selector.
interface clk_sel_glitchfree_if;

    logic [1:0] i_sel;
    logic       i_req;
    logic       o_ack;
    logic       o_busy;
    logic [1:0] o_cur_sel;

    modport master (
        output i_sel,
        output i_req,
        input  o_ack,
        input  o_busy,
        input  o_cur_sel
    );

    modport slave (
        input  i_sel,
        input  i_req,
        output o_ack,
        output o_busy,
        output o_cur_sel
    );

endinterface

// File: rtl/clk_sel_leg.sv
`timescale 1ns/1ps
// One selector leg: request synchronizer and falling-edge enable flop in the
// leg's own clock domain, followed by the clock AND gate.
module clk_sel_leg #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_div,
    input  logic rstn,
    input  logic req,
    output logic en,
    output logic clk_gated
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // pre-edge values; the reset branch is asynchronous through the sensitivity list.
    always_ff @(posedge clk_div or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(req);
        end
    end

    // Enable only moves while clk_div is low, so the gated clock is whole pulses.
    always_ff @(negedge clk_div or negedge rstn) begin
        if (!rstn) begin
            en <= 1'b0;
        end else begin
            en <= sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_gated = clk_div & en;

endmodule

// File: rtl/clk_sel_glitchfree.sv
`timescale 1ns/1ps
// Glitch-free 4:1 clock selector: break-before-make controller in the clk
// domain, four gated legs and the final OR onto o_clk.
module clk_sel_glitchfree
    import clk_sel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] RST_SEL     = 2'd0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_clk_div2,
    input  logic                 i_clk_div3,
    input  logic                 i_clk_div4,
    input  logic                 i_clk_div5,
    clk_sel_glitchfree_if.slave  ctl,
    output logic                 o_clk
);

    logic [N_LEGS-1:0] clk_div;
    logic [N_LEGS-1:0] en;
    logic [N_LEGS-1:0] clk_gated;
    logic [N_LEGS-1:0] stat;
    logic [N_LEGS-1:0] stat_pipe [SYNC_STAGES];

    clk_sel_state_e    state_q, state_d;
    sel_e              tgt_q, tgt_d;
    sel_e              cur_sel_q, cur_sel_d;
    logic [N_LEGS-1:0] req_q, req_d;
    logic              boot_q, boot_d;
    logic              ack_q;

    assign clk_div = {i_clk_div5, i_clk_div4, i_clk_div3, i_clk_div2};

    for (genvar g = 0; g < N_LEGS; g++) begin : g_leg
        clk_sel_leg #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_leg (
            .clk_div   (clk_div[g]),
            .rstn      (rstn),
            .req       (req_q[g]),
            .en        (en[g]),
            .clk_gated (clk_gated[g])
        );
    end

    // NOTE: this is a handful of synchronizer flops, not a RAM, so it is reset
    // like any other register; only true memories are left without reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stat_pipe[i] <= '0;
            end
        end else begin
            stat_pipe[0] <= en;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stat_pipe[i] <= stat_pipe[i-1];
            end
        end
    end

    assign stat = stat_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RAISE;
            tgt_q     <= sel_e'(RST_SEL);
            cur_sel_q <= sel_e'(RST_SEL);
            req_q     <= '0;
            boot_q    <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_sel_q <= cur_sel_d;
            req_q     <= req_d;
            boot_q    <= boot_d;
            ack_q     <= (state_q == ACK);
        end
    end

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cur_sel_d = cur_sel_q;
        req_d     = req_q;
        boot_d    = boot_q;
        unique case (state_q)
            IDLE: begin
                if (ctl.i_req) begin
                    tgt_d = sel_e'(ctl.i_sel);
                    if ((sel_e'(ctl.i_sel) == cur_sel_q) && stat[ctl.i_sel]) begin
                        state_d = ACK;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                req_d = '0;
                if (stat == '0) begin
                    state_d = RAISE;
                end
            end
            RAISE: begin
                req_d     = sel_onehot(tgt_q);
                cur_sel_d = tgt_q;
                // The post-reset bring-up completes silently, without an ack.
                if (stat[tgt_q]) begin
                    state_d = boot_q ? IDLE : ACK;
                    boot_d  = 1'b0;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ctl.o_ack     = ack_q;
    assign ctl.o_busy    = (state_q != IDLE);
    assign ctl.o_cur_sel = cur_sel_q;

    assign o_clk = |clk_gated;

endmodule

// File: tb/tb_clk_sel_glitchfree.sv
`timescale 1ns/1ps
// Directed bench for clk_sel_glitchfree: switch table plus bring-up, same-leg,
// busy-drop and mid-switch reset sequences, with a phase-width monitor on o_clk.
module tb_clk_sel_glitchfree;

    typedef struct {
        logic [1:0] sel;
        int         max_cyc;
        int         exp_per;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] dclk;
    int         cnt [4];
    logic       o_clk;

    int      n_tests = 0;
    int      n_fail = 0;
    int      ack_count = 0;
    int      glitch_cnt = 0;
    bit      glitch_en = 1'b0;
    realtime last_edge = 0.0;

    vec_t vecs [6];

    clk_sel_glitchfree_if ctl ();

    clk_sel_glitchfree #(
        .SYNC_STAGES (2),
        .RST_SEL     (2'd0)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_clk_div2 (dclk[0]),
        .i_clk_div3 (dclk[1]),
        .i_clk_div4 (dclk[2]),
        .i_clk_div5 (dclk[3]),
        .ctl        (ctl),
        .o_clk      (o_clk)
    );

    always #5 clk = ~clk;

    // Divider model: divN is high for floor(N/2) clk cycles, low otherwise.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]  <= 0;
                dclk[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                dclk[i] <= (cnt[i] < (i + 2) / 2);
                cnt[i]  <= (cnt[i] == i + 1) ? 0 : cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (ctl.o_ack) ack_count++;
    end

    always @(o_clk) begin
        if (glitch_en && ($realtime - last_edge < 9.5)) glitch_cnt++;
        last_edge = $realtime;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_busy_low(input int max, output int cycles);
        cycles = 0;
        while (ctl.o_busy && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic track_div2(input int n, output int mism);
        mism = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_clk !== dclk[0]) mism++;
        end
    endtask

    task automatic measure_period(output int per);
        logic prev;
        int   rise_at;
        per     = -1;
        rise_at = -1;
        @(negedge clk);
        prev = o_clk;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!prev && o_clk) begin
                if (rise_at >= 0) begin
                    per = k - rise_at;
                    break;
                end
                rise_at = k;
            end
            prev = o_clk;
        end
    endtask

    task automatic pulse_req(input logic [1:0] sel);
        ctl.i_sel = sel;
        ctl.i_req = 1'b1;
        @(negedge clk);
        ctl.i_req = 1'b0;
    endtask

    task automatic wait_ack(input int max, output int cycles);
        cycles = 0;
        while (!ctl.o_ack && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int mism;
        int per;
        int ack0;

        vecs[0] = '{2'd3, 30, 5};
        vecs[1] = '{2'd0, 40, 2};
        vecs[2] = '{2'd1, 40, 3};
        vecs[3] = '{2'd2, 40, 4};
        vecs[4] = '{2'd3, 40, 5};
        vecs[5] = '{2'd0, 40, 2};

        ctl.i_sel = 2'd0;
        ctl.i_req = 1'b0;
        rstn      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_o_clk", o_clk, 0);
        check("rst_ack", ctl.o_ack, 0);
        check("rst_busy", ctl.o_busy, 1);
        check("rst_cur_sel", ctl.o_cur_sel, 0);

        // Bring-up onto div2
        rstn = 1'b1;
        wait_busy_low(12, cyc);
        check("bringup_busy_low", ctl.o_busy, 0);
        check("bringup_no_ack", ack_count, 0);
        check("bringup_cur_sel", ctl.o_cur_sel, 0);
        glitch_en = 1'b1;
        track_div2(12, mism);
        check("bringup_track_div2", mism, 0);

        // Same-leg request: ack exactly two cycles after the request cycle
        ack0 = ack_count;
        ctl.i_sel = 2'd0;
        ctl.i_req = 1'b1;
        @(negedge clk);
        ctl.i_req = 1'b0;
        check("same_ack_early", ctl.o_ack, 0);
        check("same_busy", ctl.o_busy, 1);
        mism = (o_clk !== dclk[0]) ? 1 : 0;
        @(negedge clk);
        check("same_ack", ctl.o_ack, 1);
        check("same_busy_low", ctl.o_busy, 0);
        if (o_clk !== dclk[0]) mism++;
        track_div2(10, cyc);
        check("same_track_div2", mism + cyc, 0);
        check("same_ack_count", ack_count - ack0, 1);

        // Switch table: 0->3, then 3->0, then sweep 0->1->2->3->0
        for (int i = 0; i < 6; i++) begin
            ack0 = ack_count;
            pulse_req(vecs[i].sel);
            wait_ack(vecs[i].max_cyc, cyc);
            check($sformatf("sw%0d_ack", i), ctl.o_ack, 1);
            check($sformatf("sw%0d_cur_sel", i), ctl.o_cur_sel, int'(vecs[i].sel));
            measure_period(per);
            check($sformatf("sw%0d_period", i), per, vecs[i].exp_per);
            check($sformatf("sw%0d_ack_count", i), ack_count - ack0, 1);
            check($sformatf("sw%0d_glitch", i), glitch_cnt, 0);
        end

        // Request while busy is dropped
        ack0 = ack_count;
        pulse_req(2'd1);
        repeat (3) @(negedge clk);
        check("busy_mid_switch", ctl.o_busy, 1);
        pulse_req(2'd2);
        wait_ack(40, cyc);
        check("busy_ack", ctl.o_ack, 1);
        repeat (40) @(negedge clk);
        check("busy_ack_count", ack_count - ack0, 1);
        check("busy_cur_sel", ctl.o_cur_sel, 1);
        measure_period(per);
        check("busy_period", per, 3);

        // Reset during DROP while o_clk is high
        ack0 = ack_count;
        pulse_req(2'd2);
        cyc = 0;
        while (!o_clk && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_o_clk_high", o_clk, 1);
        check("mid_busy", ctl.o_busy, 1);
        glitch_en = 1'b0;
        rstn      = 1'b0;
        #1;
        check("mid_rst_o_clk", o_clk, 0);
        check("mid_rst_cur_sel", ctl.o_cur_sel, 0);
        check("mid_rst_busy", ctl.o_busy, 1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_busy_low(12, cyc);
        check("mid_bringup_busy_low", ctl.o_busy, 0);
        check("mid_bringup_cur_sel", ctl.o_cur_sel, 0);
        check("mid_no_ack", ack_count - ack0, 0);
        glitch_en = 1'b1;
        track_div2(12, mism);
        check("mid_track_div2", mism, 0);

        check("final_glitch", glitch_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
